// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side arbiter.
//   state_t   - arbiter FSM encoding
//   HDR_TAG   - upper nibble of the per-packet source-ID header byte
//   cnt_width - bit width needed for the inactivity counter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_GUARD = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Width of a counter that must reach t-1; never narrower than one bit.
  function automatic int cnt_width(input int t);
    int w;
    w = $clog2(t);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req - request vector, one bit per source
//   ptr - index of the most recently served source
//   win - first requesting index after ptr, wrapping modulo NUM_REQ
//   any - at least one request is present
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         win,
  output logic               any
);

  always_comb begin
    int idx;
    win = '0;
    any = 1'b0;
    idx = 0;
    // Walk offsets 1..NUM_REQ so ptr itself is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && (j == idx) && req[j]) begin
          any = 1'b1;
          win = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// NUM_REQ AXI-Stream packet sources. One source is granted per packet and
// holds the grant until tlast; an optional source-ID header byte precedes
// each packet. A source that stalls mid-packet is aborted after TIMEOUT
// idle cycles.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   s_tvalid     - per-source valid
//   s_tready     - per-source ready (at most one bit high)
//   s_tdata      - source i at [i*DATA_BITS +: DATA_BITS]
//   s_tlast      - per-source end of packet
//   tx_data      - byte to transmitter, valid with tx_start
//   tx_start     - one-cycle start pulse to transmitter
//   tx_busy      - transmitter shifting
//   grant_id     - current/last granted source
//   active       - packet in progress
//   timeout_err  - one-cycle pulse on abort
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no packet; arbitrate among valid sources
// ST_HDR   | issue header byte once transmitter is free
// ST_DATA  | issue next payload byte; watch for source inactivity
// ST_GUARD | one cycle for tx_busy to rise after a start pulse
// ST_DRAIN | wait for transmitter to finish, then next byte or IDLE
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int HEADER_EN = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           s_tvalid,
  output logic [NUM_REQ-1:0]           s_tready,
  input  logic [NUM_REQ*DATA_BITS-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]           s_tlast,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [2:0]                   grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t          state;
  logic [2:0]      ptr;
  logic            last_q;
  logic [CW-1:0]   cnt;

  logic [2:0]           win;
  logic                 any;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic                 xfer;
  logic [7:0]           hdr_byte;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (s_tvalid),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Mux of the granted source's stream signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign xfer     = (state == ST_DATA) && !tx_busy && sel_valid;
  assign hdr_byte = {HDR_TAG, 1'b0, grant_id};

  // Ready and start are combinational so a payload handshake and its
  // transmitter start always land in the same cycle.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_tready[i] = xfer && (grant_id == 3'(i));
    end
    tx_start = xfer || ((state == ST_HDR) && !tx_busy);
    tx_data  = '0;
    if (state == ST_HDR) begin
      tx_data = DATA_BITS'(hdr_byte);
    end else if (state == ST_DATA) begin
      tx_data = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= 3'(NUM_REQ - 1);
      grant_id    <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      active      <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (any) begin
            grant_id <= win;
            state    <= (HEADER_EN != 0) ? ST_HDR : ST_DATA;
          end
        end
        ST_HDR: begin
          cnt <= '0;
          if (!tx_busy) state <= ST_GUARD;
        end
        ST_DATA: begin
          if (xfer) begin
            last_q <= sel_last;
            cnt    <= '0;
            state  <= ST_GUARD;
          end else if (!sel_valid) begin
            if (cnt == CNT_MAX) begin
              // Abort without draining the source; it re-arbitrates later.
              timeout_err <= 1'b1;
              ptr         <= grant_id;
              cnt         <= '0;
              state       <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_GUARD: begin
          cnt   <= '0;
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          cnt <= '0;
          if (!tx_busy) begin
            if (last_q) begin
              ptr    <= grant_id;
              last_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// dut0 has the header enabled and a short timeout; dut1 has no header.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int TO   = 64;
  localparam int BUSY = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // dut0: header enabled
  logic [N-1:0]    v0, rdy0, last0;
  logic [N*DB-1:0] data0;
  logic [DB-1:0]   txd0;
  logic            start0, busy0, act0, terr0;
  logic [2:0]      gid0;

  // dut1: header disabled
  logic [N-1:0]    v1, rdy1, last1;
  logic [N*DB-1:0] data1;
  logic [DB-1:0]   txd1;
  logic            start1, busy1, act1, terr1;
  logic [2:0]      gid1;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .HEADER_EN(1), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .s_tvalid(v0), .s_tready(rdy0), .s_tdata(data0),
    .s_tlast(last0), .tx_data(txd0), .tx_start(start0), .tx_busy(busy0),
    .grant_id(gid0), .active(act0), .timeout_err(terr0)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .HEADER_EN(0), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .s_tvalid(v1), .s_tready(rdy1), .s_tdata(data1),
    .s_tlast(last1), .tx_data(txd1), .tx_start(start1), .tx_busy(busy1),
    .grant_id(gid1), .active(act1), .timeout_err(terr1)
  );

  // Transmitter models: busy for BUSY cycles starting the cycle after start.
  int bcnt0 = 0;
  int bcnt1 = 0;
  always @(posedge clk) begin
    if (start0) bcnt0 <= BUSY;
    else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
    if (start1) bcnt1 <= BUSY;
    else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
  end
  assign busy0 = (bcnt0 != 0);
  assign busy1 = (bcnt1 != 0);

  // Source models for dut0: {last, byte} per beat.
  logic [8:0] src_q [N][$];

  typedef struct {
    logic       hdr;
    int         src;
    logic [7:0] b;
  } exp_t;
  exp_t exp_q[$];

  function automatic void drive_src0();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        v0[i]             = 1'b1;
        data0[i*DB +: DB] = src_q[i][0][7:0];
        last0[i]          = src_q[i][0][8];
      end else begin
        v0[i]             = 1'b0;
        data0[i*DB +: DB] = '0;
        last0[i]          = 1'b0;
      end
    end
  endfunction

  initial begin
    logic [N-1:0] hs;
    v0 = '0; data0 = '0; last0 = '0;
    forever begin
      @(negedge clk);
      hs = rdy0 & v0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_src0();
    end
  end

  task automatic send_pkt(input int src, input int n, input logic [31:0] bytes,
                          input bit with_last);
    exp_t e;
    logic [7:0] b;
    logic lb;
    e.hdr = 1'b1;
    e.src = src;
    e.b   = 8'hA0 | 8'(src);
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      b  = bytes[k*8 +: 8];
      lb = with_last && (k == n - 1);
      src_q[src].push_back({lb, b});
      e.hdr = 1'b0;
      e.b   = b;
      exp_q.push_back(e);
    end
    drive_src0();
  endtask

  // dut0 monitor / scoreboard
  int n_terr = 0;
  int terr_cyc = 0;
  int last_data_cyc = 0;
  int first_start_cyc = -1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rdy0 != '0) begin
          check_eq("tready_onehot", 32'($countones(rdy0)), 1);
          check_eq("tready_with_start", 32'(start0), 1);
        end
        if (start0) begin
          if (first_start_cyc < 0) first_start_cyc = cyc;
          check_eq("start_not_busy", 32'(busy0), 0);
          check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq(e.hdr ? "hdr_byte" : "data_byte", 32'(txd0), 32'(e.b));
            check_eq("grant_id", 32'(gid0), e.src);
            check_eq("tready_at_start", 32'(rdy0), e.hdr ? 0 : (32'd1 << e.src));
            if (!e.hdr) last_data_cyc = cyc;
          end
        end
        if (terr0) begin
          n_terr++;
          terr_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (exp_q.size() != 0 || act0 || busy0 || v0 != '0)) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done"}, 32'(k < 3000), 1);
  endtask

  task automatic at_drive_slot();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_set;
    int k;
    int n1;
    int rdy_bad;
    bit hs1;

    v1 = '0; data1 = '0; last1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", 32'(start0), 0);
    check_eq("rst_tready", 32'(rdy0), 0);
    check_eq("rst_tx_data", 32'(txd0), 0);
    check_eq("rst_grant", 32'(gid0), 0);
    check_eq("rst_active", 32'(act0), 0);
    check_eq("rst_terr", 32'(terr0), 0);
    #2 rst = 1'b0;

    // 1: three-byte packet from source 0, arbitration latency of one cycle
    at_drive_slot();
    first_start_cyc = -1;
    t_set = cyc;
    send_pkt(0, 3, 32'h00332211, 1'b1);
    wait_done("t1");
    check_eq("t1_latency", 32'(first_start_cyc - t_set), 1);
    check_eq("t1_grant", 32'(gid0), 0);
    check_eq("t1_active_low", 32'(act0), 0);

    // 2: sources 1 and 2 together, whole packets in round-robin order
    at_drive_slot();
    send_pkt(1, 2, 32'h00006261, 1'b1);
    send_pkt(2, 2, 32'h00007271, 1'b1);
    wait_done("t2");

    // 3: source 3 served, then 0 and 3 together -> 0 wins
    at_drive_slot();
    send_pkt(3, 1, 32'h0000003C, 1'b1);
    wait_done("t3a");
    at_drive_slot();
    send_pkt(0, 1, 32'h0000000A, 1'b1);
    send_pkt(3, 1, 32'h0000003D, 1'b1);
    wait_done("t3b");

    // 4: source 2 stalls mid-packet -> timeout abort
    n_terr = 0;
    at_drive_slot();
    send_pkt(2, 1, 32'h00000044, 1'b0);
    k = 0;
    while (k < 500 && (exp_q.size() != 0 || n_terr == 0)) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_terr_seen", 32'(n_terr != 0), 1);
    check_eq("t4_terr_cycle", 32'(terr_cyc - last_data_cyc), TO + BUSY + 2);
    repeat (5) @(negedge clk);
    check_eq("t4_terr_once", 32'(n_terr), 1);
    check_eq("t4_active_low", 32'(act0), 0);
    at_drive_slot();
    send_pkt(3, 1, 32'h00000066, 1'b1);
    send_pkt(2, 1, 32'h00000055, 1'b1);
    wait_done("t4b");

    // 6: reset while the transmitter is busy mid-packet
    at_drive_slot();
    send_pkt(3, 3, 32'h00C3C2C1, 1'b1);
    k = 0;
    while (k < 500 && !(exp_q.size() == 2 && busy0)) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_mid_packet", 32'(k < 500), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_tx_start", 32'(start0), 0);
    check_eq("t6_rst_tready", 32'(rdy0), 0);
    check_eq("t6_rst_tx_data", 32'(txd0), 0);
    check_eq("t6_rst_grant", 32'(gid0), 0);
    check_eq("t6_rst_active", 32'(act0), 0);
    check_eq("t6_rst_terr", 32'(terr0), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive_src0();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    at_drive_slot();
    send_pkt(0, 1, 32'h000000D0, 1'b1);
    send_pkt(3, 1, 32'h000000D3, 1'b1);
    wait_done("t6");

    // 5: no header, single-beat packet on dut1
    n1 = 0;
    rdy_bad = 0;
    hs1 = 1'b0;
    at_drive_slot();
    v1[1] = 1'b1;
    data1[15:8] = 8'h5A;
    last1[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (start1) begin
        n1++;
        check_eq("t5_data", 32'(txd1), 32'h5A);
        check_eq("t5_tready", 32'(rdy1), 32'b0010);
        hs1 = 1'b1;
      end else if (rdy1 != '0) begin
        rdy_bad++;
      end
      @(posedge clk);
      #2;
      if (hs1) begin
        v1 = '0;
        data1 = '0;
        last1 = '0;
      end
    end
    check_eq("t5_start_count", 32'(n1), 1);
    check_eq("t5_tready_stray", 32'(rdy_bad), 0);
    check_eq("t5_grant", 32'(gid1), 1);
    check_eq("t5_active_low", 32'(act1), 0);
    check_eq("t5_no_terr", 32'(terr1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
